// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the dmem_responder slice.
package dmem_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
    localparam int DATA_W = 32;
    localparam int MASK_W = 8;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
endpackage

// File: rtl/dmem_lat_lfsr.sv
// dmem_lat_lfsr: 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) for random latency.
// Instantiated by dmem_responder only when DMEM_RAND_LAT_EN is defined.
module dmem_lat_lfsr
    import dmem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] out
);
    always_ff @(posedge clk)
        out <= !rst ? LFSR_SEED : (out >> 1) ^ (out[0] ? LFSR_TAPS : 16'h0);
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: byte-writable data memory answering LSU requests after a latency.
// Define DMEM_RAND_LAT_EN for per-request random latency in 1..MAX_LAT.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH   = 1024,
    parameter logic [31:0] BASE    = 32'h8000_0000,
    parameter int          LATENCY = 2,
    parameter int          MAX_LAT = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              ren,
    input  logic              wen,
    input  logic [MASK_W-1:0] wmask,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] rdata,
    output logic              resp_err
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    state_e            state_q;
    logic [7:0]        cnt_q;
    logic              wen_q;
    logic [3:0]        wmask_q;
    logic [31:0]       addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [31:0]       off;
    logic              hit;
    logic [AW-1:0]     idx;
    logic              done;
    logic [3:0]        be;
    logic [DATA_W-1:0] bm, mem_rd, wr_word_d, rdata_d;
    logic [7:0]        lat_m1;
    logic              unused_ok;

`ifdef DMEM_RAND_LAT_EN
    logic [15:0] lfsr;
    dmem_lat_lfsr u_lfsr (.clk(clk), .rst(rst), .out(lfsr));
    assign lat_m1    = 8'(32'(lfsr[2:0]) % MAX_LAT);
    assign unused_ok = ^{wmask[7:4], lfsr[15:3]};
`else
    assign lat_m1    = 8'(LATENCY - 1);
    assign unused_ok = ^wmask[7:4];
`endif

    assign off    = addr_q - BASE;
    assign hit    = off < 32'(4 * DEPTH);
    assign idx    = off[AW+1:2];
    assign done   = state_q == WAIT && cnt_q == 8'd0;
    assign mem_rd = mem[idx];
    // lanes shifted past byte 3 fall off the top instead of wrapping
    assign be        = wmask_q << addr_q[1:0];
    assign bm        = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    assign wr_word_d = (mem_rd & ~bm) | ((wdata_q << {addr_q[1:0], 3'b0}) & bm);
    assign rdata_d   = hit ? (wen_q ? wr_word_d : mem_rd) >> {addr_q[1:0], 3'b0} : '0;

    always_ff @(posedge clk)
        if (rst && done && hit && wen_q)
            mem[idx] <= wr_word_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            rdata      <= '0;
            resp_err   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            case (state_q)
                IDLE: if (req_valid && (ren || wen)) begin
                    state_q   <= WAIT;
                    req_ready <= 1'b0;
                    cnt_q     <= lat_m1;
                    wen_q     <= wen;
                    wmask_q   <= wmask[3:0];
                    addr_q    <= addr;
                    wdata_q   <= wdata;
                end
                WAIT: if (done) begin
                    state_q    <= RESP;
                    resp_valid <= 1'b1;
                    rdata      <= rdata_d;
                    resp_err   <= !hit;
                end else begin
                    cnt_q <= cnt_q - 8'd1;
                end
                RESP: begin
                    state_q    <= IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    req_ready  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
